// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: datapath widths,
// the bubble instruction and the {inst, pc} fetch-entry record.
package fetch_decode_queue_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DEPTH = 4;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// IF->ID instruction queue: buffers up to DEPTH fetched {inst, pc} pairs so fetch
// can run ahead of decode stalls; a taken jump/branch flushes every entry.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int              XLEN  = fetch_decode_queue_pkg::XLEN,
  parameter int              ILEN  = fetch_decode_queue_pkg::ILEN,
  parameter int              DEPTH = fetch_decode_queue_pkg::DEPTH,
  parameter logic [ILEN-1:0] NOP   = NOP_INST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ILEN-1:0]            in_inst,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       in_ready,
  input  logic                       jb,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [ILEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enq, deq;

  // Handshake: an entry moves on a rising edge when valid and ready are both high
  // in that cycle. Upstream: in_valid/in_ready, and fetch must hold its offer
  // until accepted. Downstream: out_valid with ~stall acting as ready. Both
  // ready/valid outputs depend on occupancy alone, so no input reaches an output.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & ~stall;
  assign count     = count_q;

  // Stale storage past the head is masked so an empty queue always shows a bubble.
  assign out_inst = out_valid ? mem_q[rd_ptr_q].inst : NOP;
  assign out_pc   = out_valid ? mem_q[rd_ptr_q].pc   : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (jb) begin
      // Flush wins over both enqueue and dequeue; the offered entry is dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q].inst = in_inst;
        mem_d[wr_ptr_q].pc   = in_pc;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CW'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].inst <= NOP;
        mem_q[i].pc   <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised bench for fetch_decode_queue: a queue-of-entries reference model
// predicts occupancy and the head entry after every clock.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [ILEN-1:0]   in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              in_ready;
  logic              jb;
  logic              stall;
  logic              out_valid;
  logic [ILEN-1:0]   out_inst;
  logic [XLEN-1:0]   out_pc;
  logic [CW-1:0]     count;

  fetch_decode_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .jb        (jb),
    .stall     (stall),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .count     (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  fetch_entry_t    exp_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [ILEN-1:0] cur_inst;
  logic [XLEN-1:0] cur_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("count", 64'(count), 64'(n));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("in_ready", 64'(in_ready), 64'(n != DEPTH));
    check("out_inst", 64'(out_inst), (n != 0) ? 64'(exp_q[0].inst) : 64'(NOP_INST));
    check("out_pc", 64'(out_pc), (n != 0) ? 64'(exp_q[0].pc) : 64'(0));
  endtask

  // driver: called at a falling edge; applies one cycle of stimulus, then checks
  // the state seen after the next rising edge.
  task automatic drive_cycle(input logic v, input logic s, input logic j);
    bit accept;
    bit pop;
    in_valid = v;
    stall    = s;
    jb       = j;
    in_inst  = cur_inst;
    in_pc    = cur_pc;
    accept   = v && (exp_q.size() != DEPTH);
    pop      = (exp_q.size() != 0) && !s;
    if (j) begin
      exp_q.delete();
      cur_pc   = {32'h0, $urandom} & ~64'h3;
      cur_inst = $urandom;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (accept) begin
        exp_q.push_back('{inst: cur_inst, pc: cur_pc});
        cur_pc   = cur_pc + 64'd4;
        cur_inst = $urandom;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_inst = '0;
    in_pc = '0;
    jb = 1'b0;
    stall = 1'b0;
    cur_inst = $urandom;
    cur_pc = '0;

    // 1. reset values
    repeat (2) @(negedge clk);
    check_outputs();
    check("rst_out_inst", 64'(out_inst), 64'h13);
    rst = 1'b0;
    @(negedge clk);

    // 2. fill under stall; fifth offer (0x10) must be refused
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(in_ready), 64'd0);

    // 3. drain with continuous fetch; pointers wrap several times
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 1'b0);

    // 4. simultaneous enq + deq at count 2
    drive_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0);
    check("enqdeq_count", 64'(count), 64'd2);

    // 5. flush at count 3 with in_valid and stall high
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("pre_flush_count", 64'(count), 64'd3);
    drive_cycle(1'b1, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_pc", 64'(out_pc), 64'd0);

    // 6. asynchronous reset between edges with two entries held
    drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("pre_rst_count", 64'(count), 64'd2);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check_outputs();
    check("async_rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 99) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
